// File: rtl/spdif_relay_sequencer.sv
// Sequences the S/PDIF receive-to-retransmit path: acquire lock, prime the FIFO, play out.
// Flushes on kill or loss of signal, counts overruns/underruns and latches channel status.
module spdif_relay_sequencer #(
    parameter int unsigned LEVEL_W        = 10,
    parameter int unsigned PRIME_LEVEL    = 512,
    parameter int unsigned LOCK_BLOCKS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned FLUSH_CYCLES   = 4
) (
    input  logic               i_clk_60mhz,
    input  logic               i_rst,
    input  logic               i_sample_valid,
    input  logic               i_block_done,
    input  logic               i_block_kill,
    input  logic [191:0]       i_channel_status,
    input  logic               i_fifo_full,
    input  logic               i_fifo_empty,
    input  logic [LEVEL_W-1:0] i_fifo_level,
    input  logic               i_rd_req_async,
    output logic               o_fifo_wr_en,
    output logic               o_fifo_rd_en,
    output logic               o_fifo_flush,
    output logic               o_play_en,
    output logic               o_locked,
    output logic [2:0]         o_state,
    output logic [31:0]        o_cs_word,
    output logic               o_cs_valid,
    output logic [7:0]         o_overrun_cnt,
    output logic [7:0]         o_underrun_cnt
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAcquire = 3'd1,
        StFill    = 3'd2,
        StPlay    = 3'd3,
        StFlush   = 3'd4
    } state_t;

    localparam int unsigned GOOD_W = $clog2(LOCK_BLOCKS + 1);
    localparam int unsigned SIL_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [GOOD_W-1:0]  GOOD_LOCK = GOOD_W'(LOCK_BLOCKS);
    localparam logic [SIL_W-1:0]   SIL_LAST  = SIL_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FCNT_W-1:0]  FCNT_LAST = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] PRIME     = LEVEL_W'(PRIME_LEVEL);

    state_t              r_state;
    logic                r_play_en;
    logic                r_locked;
    logic                r_flush;
    logic                r_rd_en;
    logic                r_s1;
    logic                r_s2;
    logic                r_prev;
    logic [GOOD_W-1:0]   r_good_cnt;
    logic [SIL_W-1:0]    r_silence;
    logic [FCNT_W-1:0]   r_flush_cnt;
    logic [7:0]          r_overrun_cnt;
    logic [7:0]          r_underrun_cnt;
    logic [31:0]         r_cs_word;
    logic [31:0]         r_cs_cand;
    logic                r_cs_valid;

    state_t              w_state_next;
    logic                w_active;
    logic                w_rd_edge;
    logic                w_good_block;
    logic                w_timeout;
    logic                w_flush_entry;
    logic                w_underrun;
    logic                w_overrun;
    logic                w_unused_cs;

    assign w_active      = (r_state == StFill) || (r_state == StPlay);
    assign w_rd_edge     = r_s2 && !r_prev;
    assign w_good_block  = i_block_done && !i_block_kill;
    // Last silent cycle before the silence run reaches the timeout.
    assign w_timeout     = w_active && !i_sample_valid && (r_silence == SIL_LAST);
    assign w_flush_entry = w_active && (i_block_kill || w_timeout);
    assign w_underrun    = (r_state == StPlay) && w_rd_edge && i_fifo_empty;
    assign w_overrun     = w_active && i_sample_valid && i_fifo_full;
    assign w_unused_cs   = ^i_channel_status[191:32];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:    w_state_next = StAcquire;
            StAcquire: if (r_good_cnt == GOOD_LOCK) w_state_next = StFill;
            StFill: begin
                if (w_flush_entry)              w_state_next = StFlush;
                else if (i_fifo_level >= PRIME) w_state_next = StPlay;
            end
            StPlay: begin
                if (w_flush_entry)   w_state_next = StFlush;
                else if (w_underrun) w_state_next = StFill;
            end
            StFlush:   if (r_flush_cnt == FCNT_LAST) w_state_next = StAcquire;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk_60mhz) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_play_en      <= 1'b0;
            r_locked       <= 1'b0;
            r_flush        <= 1'b0;
            r_rd_en        <= 1'b0;
            r_s1           <= 1'b0;
            r_s2           <= 1'b0;
            r_prev         <= 1'b0;
            r_good_cnt     <= '0;
            r_silence      <= '0;
            r_flush_cnt    <= '0;
            r_overrun_cnt  <= 8'd0;
            r_underrun_cnt <= 8'd0;
            r_cs_word      <= 32'd0;
            r_cs_cand      <= 32'd0;
            r_cs_valid     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_play_en <= (w_state_next == StPlay);
            r_locked  <= (w_state_next == StFill) || (w_state_next == StPlay);
            r_flush   <= (w_state_next == StFlush);

            r_s1   <= i_rd_req_async;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            // A read issued in the flush-entry cycle would overlap the flush pulse.
            r_rd_en <= w_rd_edge && (r_state == StPlay) && !i_fifo_empty && !w_flush_entry;

            if (r_state != StAcquire || r_good_cnt == GOOD_LOCK) begin
                r_good_cnt <= '0;
            end else if (i_block_done && i_block_kill) begin
                r_good_cnt <= '0;
            end else if (w_good_block) begin
                r_good_cnt <= r_good_cnt + GOOD_W'(1);
            end

            if (!w_active || i_sample_valid) r_silence <= '0;
            else                             r_silence <= r_silence + SIL_W'(1);

            if (r_state == StFlush) r_flush_cnt <= r_flush_cnt + FCNT_W'(1);
            else                    r_flush_cnt <= '0;

            if (w_overrun && r_overrun_cnt != 8'hFF) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
            if (w_underrun && r_underrun_cnt != 8'hFF) begin
                r_underrun_cnt <= r_underrun_cnt + 8'd1;
            end

            // Two identical consecutive good blocks are required before the display word moves.
            if (w_good_block && r_state != StIdle) begin
                r_cs_cand <= i_channel_status[31:0];
                if (i_channel_status[31:0] == r_cs_cand) begin
                    r_cs_word  <= i_channel_status[31:0];
                    r_cs_valid <= 1'b1;
                end
            end
        end
    end

    assign o_fifo_wr_en   = i_sample_valid && !i_fifo_full && w_active;
    assign o_fifo_rd_en   = r_rd_en;
    assign o_fifo_flush   = r_flush;
    assign o_play_en      = r_play_en;
    assign o_locked       = r_locked;
    assign o_state        = r_state;
    assign o_cs_word      = r_cs_word;
    assign o_cs_valid     = r_cs_valid;
    assign o_overrun_cnt  = r_overrun_cnt;
    assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_spdif_relay_sequencer.sv
// Randomized self-checking bench for spdif_relay_sequencer against a behavioural model.
module tb_spdif_relay_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACQ  = 3'd1;
    localparam logic [2:0] S_FILL = 3'd2;
    localparam logic [2:0] S_PLAY = 3'd3;
    localparam logic [2:0] S_FLSH = 3'd4;

    logic         clk_60mhz = 1'b0;
    logic         rst;
    logic         i_sample_valid, i_block_done, i_block_kill;
    logic [191:0] i_channel_status;
    logic         i_fifo_full, i_fifo_empty;
    logic [9:0]   i_fifo_level;
    logic         i_rd_req_async;
    logic         o_fifo_wr_en, o_fifo_rd_en, o_fifo_flush, o_play_en, o_locked;
    logic [2:0]   o_state;
    logic [31:0]  o_cs_word;
    logic         o_cs_valid;
    logic [7:0]   o_overrun_cnt, o_underrun_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model state
    int          m_over;
    int          m_under;
    logic [31:0] m_prev_cs;
    logic [31:0] m_word;
    logic        m_valid;

    always #8 clk_60mhz = ~clk_60mhz;

    spdif_relay_sequencer dut (
        .i_clk_60mhz      (clk_60mhz),
        .i_rst            (rst),
        .i_sample_valid   (i_sample_valid),
        .i_block_done     (i_block_done),
        .i_block_kill     (i_block_kill),
        .i_channel_status (i_channel_status),
        .i_fifo_full      (i_fifo_full),
        .i_fifo_empty     (i_fifo_empty),
        .i_fifo_level     (i_fifo_level),
        .i_rd_req_async   (i_rd_req_async),
        .o_fifo_wr_en     (o_fifo_wr_en),
        .o_fifo_rd_en     (o_fifo_rd_en),
        .o_fifo_flush     (o_fifo_flush),
        .o_play_en        (o_play_en),
        .o_locked         (o_locked),
        .o_state          (o_state),
        .o_cs_word        (o_cs_word),
        .o_cs_valid       (o_cs_valid),
        .o_overrun_cnt    (o_overrun_cnt),
        .o_underrun_cnt   (o_underrun_cnt)
    );

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic tick();
        @(posedge clk_60mhz);
        #1;
    endtask

    task automatic model_reset();
        m_over = 0;
        m_under = 0;
        m_prev_cs = 32'd0;
        m_word = 32'd0;
        m_valid = 1'b0;
    endtask

    task automatic send_block(input logic [31:0] cs, input logic kill);
        logic [191:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        v[31:0] = cs;
        i_channel_status = v;
        i_block_done = 1'b1;
        i_block_kill = kill;
        tick();
        i_block_done = 1'b0;
        i_block_kill = 1'b0;
        if (!kill) begin
            if (cs == m_prev_cs) begin
                m_word = cs;
                m_valid = 1'b1;
            end
            m_prev_cs = cs;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_sample_valid = 1'b0; i_block_done = 1'b0; i_block_kill = 1'b0;
        i_channel_status = '0; i_fifo_full = 1'b0; i_fifo_empty = 1'b0;
        i_fifo_level = '0; i_rd_req_async = 1'b0;
        model_reset();
        repeat (3) tick();
        tests_run++;
        if (o_state !== S_IDLE) begin
            tests_failed++; $display("FAIL reset_state: got %0d want %0d", o_state, S_IDLE);
        end
        tests_run++;
        if ({o_fifo_wr_en, o_fifo_rd_en, o_fifo_flush, o_play_en, o_locked, o_cs_valid} !== 6'b0)
        begin
            tests_failed++;
            $display("FAIL reset_flags: got wr%b rd%b fl%b pl%b lk%b cv%b want all 0", o_fifo_wr_en,
                     o_fifo_rd_en, o_fifo_flush, o_play_en, o_locked, o_cs_valid);
        end
        tests_run++;
        if (o_cs_word !== 32'd0 || o_overrun_cnt !== 8'd0 || o_underrun_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_regs: got cs=%h ov=%0d un=%0d want 0", o_cs_word, o_overrun_cnt,
                     o_underrun_cnt);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (o_state !== S_ACQ) begin
            tests_failed++; $display("FAIL reset_release: got %0d want %0d", o_state, S_ACQ);
        end
    endtask

    task automatic test_lock();
        int   consec;
        logic kills [4];
        logic [2:0] exp_state;
        kills = '{1'b0, 1'b1, 1'b0, 1'b0};
        consec = 0;
        // Samples and read requests outside FILL/PLAY are ignored
        i_sample_valid = 1'b1; i_fifo_full = 1'b1; #1;
        tests_run++;
        if (o_fifo_wr_en !== 1'b0) begin
            tests_failed++; $display("FAIL acq_wr_en: got %b want 0", o_fifo_wr_en);
        end
        tick();
        i_sample_valid = 1'b0; i_fifo_full = 1'b0;
        i_rd_req_async = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests_run++;
            if (o_fifo_rd_en !== 1'b0) begin
                tests_failed++; $display("FAIL acq_rd_en cyc%0d: got %b want 0", k, o_fifo_rd_en);
            end
        end
        i_rd_req_async = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (o_overrun_cnt !== 8'd0 || o_underrun_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL acq_counters: got ov=%0d un=%0d want 0 0", o_overrun_cnt, o_underrun_cnt);
        end
        for (int b = 0; b < 4; b++) begin
            send_block($urandom, kills[b]);
            consec = kills[b] ? 0 : consec + 1;
            repeat (2 + $urandom_range(0, 2)) tick();
            exp_state = (consec >= 2) ? S_FILL : S_ACQ;
            tests_run++;
            if (o_state !== exp_state || o_locked !== (consec >= 2)) begin
                tests_failed++;
                $display("FAIL lock_blk%0d: got state=%0d locked=%b want state=%0d", b, o_state,
                         o_locked, exp_state);
            end
        end
        tests_run++;
        if (o_cs_word !== m_word || o_cs_valid !== m_valid) begin
            tests_failed++;
            $display("FAIL lock_cs: got %h/%b want %h/%b", o_cs_word, o_cs_valid, m_word, m_valid);
        end
    endtask

    task automatic test_fill();
        int   lvl;
        logic sv, fu;
        lvl = 0;
        i_fifo_level = '0;
        while (lvl < 512) begin
            sv = ($urandom_range(0, 3) != 0);
            fu = sv && ($urandom_range(0, 15) == 0);
            i_sample_valid = sv; i_fifo_full = fu;
            #1;
            tests_run++;
            if (o_fifo_wr_en !== (sv && !fu) || o_state !== S_FILL) begin
                tests_failed++;
                $display("FAIL fill_wr lvl%0d: got wr=%b state=%0d want wr=%b state=%0d", lvl,
                         o_fifo_wr_en, o_state, sv && !fu, S_FILL);
            end
            if (sv && fu) m_over++;
            if (sv && !fu) lvl++;
            tick();
            i_fifo_level = 10'(lvl);
        end
        i_sample_valid = 1'b0; i_fifo_full = 1'b0;
        #1;
        tests_run++;
        if (o_state !== S_FILL) begin
            tests_failed++; $display("FAIL fill_hold_512: got %0d want %0d", o_state, S_FILL);
        end
        tick();
        tests_run++;
        if (o_state !== S_PLAY || o_play_en !== 1'b1 || o_locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_to_play: got state=%0d play=%b locked=%b want %0d 1 1", o_state,
                     o_play_en, o_locked, S_PLAY);
        end
        tests_run++;
        if (o_overrun_cnt !== 8'(sat(m_over))) begin
            tests_failed++; $display("FAIL overrun_cnt: got %0d want %0d", o_overrun_cnt, sat(m_over));
        end
    endtask

    task automatic test_read();
        int hold, pulses, at;
        i_sample_valid = 1'b1; i_fifo_empty = 1'b0;
        for (int r = 0; r < 3; r++) begin
            hold = (r == 0) ? 20 : $urandom_range(5, 20);
            pulses = 0; at = -1;
            i_rd_req_async = 1'b1;
            for (int k = 1; k <= hold + 4; k++) begin
                if (k == hold + 1) i_rd_req_async = 1'b0;
                tick();
                if (o_fifo_rd_en === 1'b1) begin
                    pulses++; at = k;
                    tests_run++;
                    if (o_fifo_flush !== 1'b0) begin
                        tests_failed++; $display("FAIL read_flush_overlap: got 1 want 0");
                    end
                end
            end
            tests_run++;
            if (pulses != 1 || at != 3) begin
                tests_failed++;
                $display("FAIL read_pulse rep%0d: got %0d pulses at edge %0d want 1 at 3", r,
                         pulses, at);
            end
            tests_run++;
            if (o_state !== S_PLAY || o_underrun_cnt !== 8'(sat(m_under))) begin
                tests_failed++;
                $display("FAIL read_state rep%0d: got %0d un=%0d want %0d un=%0d", r, o_state,
                         o_underrun_cnt, S_PLAY, sat(m_under));
            end
        end
    endtask

    task automatic test_underrun();
        int rd_seen;
        i_fifo_empty = 1'b1;
        for (int e = 0; e < 300; e++) begin
            rd_seen = 0;
            i_rd_req_async = 1'b1;
            repeat (3) begin
                tick();
                if (o_fifo_rd_en !== 1'b0) rd_seen++;
            end
            m_under++;
            tests_run++;
            if (o_underrun_cnt !== 8'(sat(m_under)) || rd_seen != 0) begin
                tests_failed++;
                $display("FAIL underrun ev%0d: got cnt=%0d rd=%0d want cnt=%0d rd=0", e,
                         o_underrun_cnt, rd_seen, sat(m_under));
            end
            if (e == 0) begin
                tests_run++;
                if (o_state !== S_FILL) begin
                    tests_failed++; $display("FAIL underrun_state: got %0d want %0d", o_state, S_FILL);
                end
            end
            i_rd_req_async = 1'b0;
            repeat (4) tick();
        end
        tests_run++;
        if (o_state !== S_PLAY || o_underrun_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL underrun_sat: got state=%0d cnt=%0d want %0d 255", o_state,
                     o_underrun_cnt, S_PLAY);
        end
        i_fifo_empty = 1'b0;
    endtask

    task automatic test_timeout();
        int n, fl, guard;
        i_sample_valid = 1'b0;
        n = 0;
        while (o_state !== S_FLSH && n < 5000) begin
            tick();
            n++;
        end
        tests_run++;
        if (n != 4096) begin
            tests_failed++; $display("FAIL timeout_cycles: got %0d want 4096", n);
        end
        i_sample_valid = 1'b1;
        fl = 0; guard = 0;
        while (o_state === S_FLSH && guard < 10) begin
            #1;
            if (o_fifo_flush === 1'b1) fl++;
            tests_run++;
            if (o_fifo_wr_en !== 1'b0 || o_fifo_rd_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_overlap: got wr=%b rd=%b want 0 0", o_fifo_wr_en, o_fifo_rd_en);
            end
            tick();
            guard++;
        end
        tests_run++;
        if (fl != 4 || o_state !== S_ACQ || o_fifo_flush !== 1'b0 || o_locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_len: got %0d cycles, state=%0d fl=%b lk=%b want 4 %0d 0 0", fl,
                     o_state, o_fifo_flush, o_locked, S_ACQ);
        end
        i_sample_valid = 1'b0;
    endtask

    task automatic test_cs();
        logic [31:0] a, b;
        do a = $urandom; while (a == m_prev_cs);
        do b = $urandom; while (b == a);
        send_block(a, 1'b0);
        repeat (2) tick();
        send_block(b, 1'b0);
        repeat (2) tick();
        tests_run++;
        if (o_cs_word !== m_word || o_cs_valid !== m_valid) begin
            tests_failed++;
            $display("FAIL cs_ab: got %h/%b want %h/%b", o_cs_word, o_cs_valid, m_word, m_valid);
        end
        send_block(b, 1'b0);
        repeat (2) tick();
        tests_run++;
        if (o_cs_word !== b || o_cs_valid !== 1'b1 || m_word !== b) begin
            tests_failed++;
            $display("FAIL cs_abb: got %h/%b want %h/1", o_cs_word, o_cs_valid, b);
        end
        // Killed block in FILL: registers untouched and the path flushes
        send_block(~b, 1'b1);
        tests_run++;
        if (o_state !== S_FLSH) begin
            tests_failed++; $display("FAIL kill_flush: got %0d want %0d", o_state, S_FLSH);
        end
        send_block(~b, 1'b0);
        m_prev_cs = b;
        repeat (5) tick();
        tests_run++;
        if (o_cs_word !== b || o_cs_valid !== 1'b1 || o_state !== S_ACQ) begin
            tests_failed++;
            $display("FAIL cs_killed: got %h/%b state=%0d want %h/1 state=%0d", o_cs_word,
                     o_cs_valid, o_state, b, S_ACQ);
        end
    endtask

    task automatic test_reset_mid();
        i_rd_req_async = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        tests_run++;
        if (o_state !== S_IDLE || o_underrun_cnt !== 8'd0 || o_overrun_cnt !== 8'd0 ||
            o_cs_valid !== 1'b0 || o_cs_word !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: got state=%0d un=%0d ov=%0d cv=%b cs=%h want all 0", o_state,
                     o_underrun_cnt, o_overrun_cnt, o_cs_valid, o_cs_word);
        end
        model_reset();
        rst = 1'b0;
        i_rd_req_async = 1'b0;
        tick();
        tests_run++;
        if (o_state !== S_ACQ || o_fifo_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_release: got state=%0d rd=%b want %0d 0", o_state,
                     o_fifo_rd_en, S_ACQ);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_fill();
        test_read();
        test_underrun();
        test_timeout();
        test_cs();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
